// File: rtl/imem_loader.sv
// imem_loader: packs a big-endian byte stream into 32-bit words and writes them
// to the instruction memory at consecutive addresses from 0. The CPU is held in
// reset from power-up until a load completes, and again during every later load.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing 8-bit sum
// byte that must match the mod-256 sum of all data bytes before done is given.
module imem_loader #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] wa,
  output logic [31:0]       wd,
  output logic              we,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RECV  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK = 3'd4;
`endif

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [31:0]       wd_q, wd_d;
  logic              err_q, err_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  logic xfer;
  logic wc_ok;
  logic last_word;

  // Handshake and status outputs are pure decodes of the current state.
  always_comb begin
    byte_ready = (state_q == S_RECV);
`ifdef IMEM_LOADER_CHECKSUM_EN
    byte_ready = byte_ready || (state_q == S_CHECK);
`endif
    we        = (state_q == S_WRITE);
    done      = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    err       = err_q;
    cpu_rst_n = cpu_rst_n_q;
    wa        = wa_q;
    wd        = wd_q;
    xfer      = byte_valid && byte_ready;
    wc_ok     = (word_count != '0) && (word_count <= DEPTH_L);
    last_word = ({1'b0, addr_q} == (count_q - ONE_L));
  end

  // Next-state logic: load sequencing, word assembly, write-port capture.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    addr_d      = addr_q;
    bcnt_d      = bcnt_q;
    word_d      = word_q;
    wa_d        = wa_q;
    wd_d        = wd_q;
    err_d       = 1'b0;
    cpu_rst_n_d = cpu_rst_n_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!wc_ok) begin
            err_d = 1'b1;
          end else begin
            count_d     = word_count;
            addr_d      = '0;
            bcnt_d      = '0;
            cpu_rst_n_d = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d       = '0;
`endif
            state_d     = S_RECV;
          end
        end
      end
      S_RECV: begin
        if (xfer) begin
          word_d = {word_q[23:0], byte_in};
          bcnt_d = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d  = sum_q + byte_in;
`endif
          // Capture address/data now so they are valid throughout WRITE and
          // hold afterwards.
          if (bcnt_q == 2'd3) begin
            wa_d    = addr_q;
            wd_d    = {word_q[23:0], byte_in};
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          addr_d  = addr_q + 1'b1;
          bcnt_d  = '0;
          state_d = S_RECV;
        end
      end
      S_DONE: begin
        cpu_rst_n_d = 1'b1;
        state_d     = S_IDLE;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (xfer) begin
          if (byte_in == sum_q) begin
            state_d = S_DONE;
          end else begin
            // Written words stay in memory; the CPU simply stays in reset.
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      addr_q      <= '0;
      bcnt_q      <= '0;
      word_q      <= '0;
      wa_q        <= '0;
      wd_q        <= '0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      bcnt_q      <= bcnt_d;
      word_q      <= word_d;
      wa_q        <= wa_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
      cpu_rst_n_q <= cpu_rst_n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

endmodule
